// File: rtl/clb_packer_if.sv
// clb_packer_if: input/output valid-ready handshakes plus flush and pending status for clb_packer
interface clb_packer_if #(
  parameter int IWIDTH = 32,
  parameter int OWIDTH = 64
);
  logic in_valid;
  logic in_ready;
  logic [IWIDTH-1:0] din;
  logic flush;
  logic out_valid;
  logic out_ready;
  logic [OWIDTH-1:0] dout;
  logic pending;
  modport master (output in_valid, din, flush, out_ready, input in_ready, out_valid, dout, pending);
  modport slave (input in_valid, din, flush, out_ready, output in_ready, out_valid, dout, pending);
endinterface

// File: rtl/clb_packer.sv
// clb_packer: packs pairs of narrow words into one double-width word (first word low), with zero-padded flush
module clb_packer #(
  parameter int IWIDTH = 32,
  parameter int OWIDTH = 64
) (
  input logic clk,
  input logic r,
  input logic en,
  clb_packer_if.slave bus
);
  typedef enum logic [1:0] {EMPTY = 2'b00, FULL = 2'b01, HALF = 2'b10, FULL_HALF = 2'b11} state_e;
  state_e state, state_n;
  logic [IWIDTH-1:0] lo_reg;
  logic [OWIDTH-1:0] out_reg, out_n;
  logic lo_v, out_v, slot_free, acc, pair, fire, load_lo, load_out;
  if (OWIDTH != 2 * IWIDTH) begin : g_width_check
    $error("clb_packer: OWIDTH must equal 2*IWIDTH");
  end
  assign lo_v = state[1];
  assign out_v = state[0];
  // Handshake decode, next state and outputs; a pairing accept outranks a flush on the same cycle
  always_comb begin
    slot_free = ~out_v | bus.out_ready;
    bus.in_ready = en & ~r & (~lo_v | slot_free);
    acc = bus.in_valid & bus.in_ready;
    pair = acc & lo_v;
    fire = en & bus.flush & lo_v & ~acc & slot_free;
    load_lo = acc & ~lo_v;
    load_out = pair | fire;
    out_n = {pair ? bus.din : {IWIDTH{1'b0}}, lo_reg};
    state_n = state_e'({load_lo | (lo_v & ~load_out), load_out | (out_v & ~(en & bus.out_ready))});
    bus.out_valid = out_v & en & ~r;
    bus.dout = r ? '0 : out_reg;
    bus.pending = lo_v & ~r;
  end
  // State and data registers; a disabled block sees no load enables and so holds everything
  always_ff @(posedge clk) begin
    if (r) begin
      state <= EMPTY;
      lo_reg <= '0;
      out_reg <= '0;
    end else begin
      state <= state_n;
      if (load_lo) lo_reg <= bus.din;
      if (load_out) out_reg <= out_n;
    end
  end
endmodule

// File: tb/tb_clb_packer.sv
// tb_clb_packer: directed cycle table plus randomized run against a word-queue reference model
module tb_clb_packer;
  typedef struct {
    logic rr, e, iv;
    logic [31:0] d;
    logic fl, ordy;
    logic x_ir, x_ov;
    logic [63:0] x_dout;
    logic x_pend;
  } vec_t;

  logic clk = 0;
  logic r = 1;
  logic en = 0;
  int checks = 0;
  int failures = 0;
  int row = 0;
  vec_t tbl[$];

  clb_packer_if #(.IWIDTH(32), .OWIDTH(64)) bus ();
  clb_packer #(.IWIDTH(32), .OWIDTH(64)) dut (.clk(clk), .r(r), .en(en), .bus(bus));

  always #5 clk = ~clk;

  function automatic vec_t v(logic rr, logic e, logic iv, logic [31:0] d, logic fl, logic ordy,
                             logic x_ir, logic x_ov, logic [63:0] x_dout, logic x_pend);
    vec_t t;
    t.rr = rr; t.e = e; t.iv = iv; t.d = d; t.fl = fl; t.ordy = ordy;
    t.x_ir = x_ir; t.x_ov = x_ov; t.x_dout = x_dout; t.x_pend = x_pend;
    return t;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h want %h", nm, row, act, exp);
    end
  endtask

  task automatic drive(logic rr, logic e, logic iv, logic [31:0] d, logic fl, logic ordy);
    r = rr; en = e; bus.in_valid = iv; bus.din = d; bus.flush = fl; bus.out_ready = ordy;
  endtask

  initial begin
    logic [31:0] held[$];
    logic [63:0] slot[$];
    logic [63:0] md;
    drive(1, 1, 0, 0, 0, 1);
    // pairing
    tbl.push_back(v(1,1,0,32'h0,0,1, 0,0,64'h0,0));
    tbl.push_back(v(0,1,1,32'hF0F0F0F0,0,1, 1,0,64'h0,0));
    tbl.push_back(v(0,1,1,32'hD0D0D0D0,0,1, 1,0,64'h0,1));
    tbl.push_back(v(0,1,0,32'h0,0,1, 1,1,64'hD0D0D0D0F0F0F0F0,0));
    tbl.push_back(v(0,1,0,32'h0,0,1, 1,0,64'hD0D0D0D0F0F0F0F0,0));
    // streaming 1..8
    tbl.push_back(v(0,1,1,32'h1,0,1, 1,0,64'hD0D0D0D0F0F0F0F0,0));
    tbl.push_back(v(0,1,1,32'h2,0,1, 1,0,64'hD0D0D0D0F0F0F0F0,1));
    tbl.push_back(v(0,1,1,32'h3,0,1, 1,1,64'h0000000200000001,0));
    tbl.push_back(v(0,1,1,32'h4,0,1, 1,0,64'h0000000200000001,1));
    tbl.push_back(v(0,1,1,32'h5,0,1, 1,1,64'h0000000400000003,0));
    tbl.push_back(v(0,1,1,32'h6,0,1, 1,0,64'h0000000400000003,1));
    tbl.push_back(v(0,1,1,32'h7,0,1, 1,1,64'h0000000600000005,0));
    tbl.push_back(v(0,1,1,32'h8,0,1, 1,0,64'h0000000600000005,1));
    tbl.push_back(v(0,1,0,32'h0,0,1, 1,1,64'h0000000800000007,0));
    // backpressure A,B,C then D
    tbl.push_back(v(0,1,1,32'hA,0,0, 1,0,64'h0000000800000007,0));
    tbl.push_back(v(0,1,1,32'hB,0,0, 1,0,64'h0000000800000007,1));
    tbl.push_back(v(0,1,1,32'hC,0,0, 1,1,64'h0000000B0000000A,0));
    tbl.push_back(v(0,1,1,32'hD,0,0, 0,1,64'h0000000B0000000A,1));
    tbl.push_back(v(0,1,1,32'hD,0,1, 1,1,64'h0000000B0000000A,1));
    tbl.push_back(v(0,1,0,32'h0,0,1, 1,1,64'h0000000D0000000C,0));
    // flush of an odd word, then flush with nothing held
    tbl.push_back(v(0,1,1,32'h12345678,0,1, 1,0,64'h0000000D0000000C,0));
    tbl.push_back(v(0,1,0,32'h0,1,1, 1,0,64'h0000000D0000000C,1));
    tbl.push_back(v(0,1,0,32'h0,1,1, 1,1,64'h0000000012345678,0));
    tbl.push_back(v(0,1,0,32'h0,1,1, 1,0,64'h0000000012345678,0));
    tbl.push_back(v(0,1,0,32'h0,0,1, 1,0,64'h0000000012345678,0));
    // flush blocked by a stalled slot
    tbl.push_back(v(0,1,1,32'h11,0,0, 1,0,64'h0000000012345678,0));
    tbl.push_back(v(0,1,1,32'h22,0,0, 1,0,64'h0000000012345678,1));
    tbl.push_back(v(0,1,1,32'h33,0,0, 1,1,64'h0000002200000011,0));
    tbl.push_back(v(0,1,0,32'h0,1,0, 0,1,64'h0000002200000011,1));
    tbl.push_back(v(0,1,0,32'h0,1,1, 1,1,64'h0000002200000011,1));
    tbl.push_back(v(0,1,0,32'h0,0,1, 1,1,64'h0000000000000033,0));
    // accept outranks flush
    tbl.push_back(v(0,1,1,32'h44,0,1, 1,0,64'h0000000000000033,0));
    tbl.push_back(v(0,1,1,32'h55,1,1, 1,0,64'h0000000000000033,1));
    tbl.push_back(v(0,1,0,32'h0,0,1, 1,1,64'h0000005500000044,0));
    // enable dropped in FULL_HALF
    tbl.push_back(v(0,1,1,32'h61,0,0, 1,0,64'h0000005500000044,0));
    tbl.push_back(v(0,1,1,32'h62,0,0, 1,0,64'h0000005500000044,1));
    tbl.push_back(v(0,1,1,32'h63,0,0, 1,1,64'h0000006200000061,0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(0,0,1,32'h64,1,1, 0,0,64'h0000006200000061,1));
    tbl.push_back(v(0,1,0,32'h0,0,1, 1,1,64'h0000006200000061,1));
    tbl.push_back(v(0,1,1,32'h64,0,1, 1,0,64'h0000006200000061,1));
    tbl.push_back(v(0,1,0,32'h0,0,1, 1,1,64'h0000006400000063,0));
    // reset mid-pair
    tbl.push_back(v(0,1,1,32'h71,0,1, 1,0,64'h0000006400000063,0));
    tbl.push_back(v(1,1,1,32'h72,0,1, 0,0,64'h0,0));
    tbl.push_back(v(0,1,1,32'h73,0,1, 1,0,64'h0,0));
    tbl.push_back(v(0,1,1,32'h74,0,1, 1,0,64'h0,1));
    tbl.push_back(v(0,1,0,32'h0,0,1, 1,1,64'h0000007400000073,0));
    tbl.push_back(v(0,1,0,32'h0,0,1, 1,0,64'h0000007400000073,0));

    repeat (2) @(posedge clk);
    foreach (tbl[i]) begin
      @(negedge clk);
      row = i;
      drive(tbl[i].rr, tbl[i].e, tbl[i].iv, tbl[i].d, tbl[i].fl, tbl[i].ordy);
      #1;
      chk("in_ready", 64'(bus.in_ready), 64'(tbl[i].x_ir));
      chk("out_valid", 64'(bus.out_valid), 64'(tbl[i].x_ov));
      chk("dout", bus.dout, tbl[i].x_dout);
      chk("pending", 64'(bus.pending), 64'(tbl[i].x_pend));
    end

    held.delete();
    slot.delete();
    md = '0;
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      logic x_ir, acc, made;
      logic [63:0] produced;
      @(negedge clk);
      row = 1000 + i;
      if (i == 0) drive(1, 1, 0, 0, 0, 0);
      else drive($urandom_range(0, 59) == 0, $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
                 $urandom, $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
      #1;
      x_ir = en && !r && (held.size() == 0 || slot.size() == 0 || bus.out_ready);
      chk("rnd in_ready", 64'(bus.in_ready), 64'(x_ir));
      chk("rnd out_valid", 64'(bus.out_valid), 64'(slot.size() != 0 && en && !r));
      chk("rnd dout", bus.dout, r ? 64'h0 : md);
      chk("rnd pending", 64'(bus.pending), 64'(held.size() != 0 && !r));
      if (r) begin
        held.delete();
        slot.delete();
        md = '0;
      end else if (en) begin
        acc = bus.in_valid && x_ir;
        made = 0;
        produced = '0;
        if (acc && held.size() == 0) held.push_back(bus.din);
        else if (acc) begin
          produced = {bus.din, held.pop_front()};
          made = 1;
        end else if (bus.flush && held.size() != 0 && (slot.size() == 0 || bus.out_ready)) begin
          produced = {32'h0, held.pop_front()};
          made = 1;
        end
        if (slot.size() != 0 && bus.out_ready) void'(slot.pop_front());
        if (made) begin
          slot.push_back(produced);
          md = produced;
        end
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
